alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction buffer depth in entries (power of two, 2..16).
REQ-002 Parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 Port clk, input, 1, single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1, asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1, upstream presents an instruction.
REQ-006 Port in_instr, input, 24, {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
REQ-007 Port in_ready, output, 1, buffer accepts in_instr this cycle.
REQ-008 Port flush, input, 1, synchronous discard of buffered and in-flight tracking state.
REQ-009 Ports func/rd/rs1/rs2, output, 4 each; addr, output, 8: registered fields driving the downstream ALU pipeline.
REQ-010 Port issue_valid, output, 1, registered; output fields hold a real instruction this cycle.
REQ-011 Port stall, output, 1, registered; high in a cycle holding a hazard bubble.
REQ-012 Port fifo_count, output, $clog2(FIFO_DEPTH)+1, current buffer occupancy.
REQ-013 Port illegal_cnt, output, CNT_W, count of dropped illegal instructions.

Function
REQ-014 in_ready SHALL equal (fifo_count < FIFO_DEPTH) and not flush; push occurs when in_valid and in_ready at a rising edge.
REQ-015 Buffer SHALL be FIFO ordered; push and pop in the same cycle leave fifo_count unchanged; no push when full even if popping.
REQ-016 Legal func values SHALL be 0..11; func 12..15 is illegal.
REQ-017 Head with illegal func SHALL be popped without issue: issue_valid=0, stall=0 next cycle, illegal_cnt increments, saturating at 2^CNT_W-1.
REQ-018 Scoreboard SHALL hold rd and valid of the last two issue slots (S0 = most recent, S1 = previous); each cycle S1<=S0, S0<=new slot (valid=0 for bubble/empty/illegal).
REQ-019 Hazard SHALL exist when legal head rs1 or rs2 equals rd of a valid S0 or S1 entry.
REQ-020 With a legal head and no hazard, head SHALL pop and fields register next cycle with issue_valid=1, stall=0; issue latency from push to issue_valid is 1 cycle minimum, 1 instruction per cycle maximum.
REQ-021 With a legal head and hazard, head SHALL stay; next cycle issue_valid=0, stall=1, func=0, other fields hold.
REQ-022 Empty buffer SHALL produce issue_valid=0, stall=0; fields hold last values.
REQ-023 Flush SHALL have top priority: next cycle fifo_count=0, S0/S1 invalid, issue_valid=0, stall=0; push that cycle dropped; illegal_cnt unaffected.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH or underflows.

Reset
REQ-025 rst_n low SHALL immediately clear FIFO pointers, fifo_count, S0/S1 valid, issue_valid, stall, illegal_cnt, and func/rd/rs1/rs2/addr to 0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered instructions; first push is accepted on the first rising edge after release.

Configuration
REQ-027 Macro ALU_ISSUE_HAZARD_CHECK_EN defined: hazard detection and bubble insertion per REQ-018..021.
REQ-028 Macro ALU_ISSUE_HAZARD_CHECK_EN undefined: no scoreboard, stall tied 0, every legal head issues the cycle it reaches the head.

Verification
REQ-029 Reset, push 0x012300 (add rd=1, rs1=2, rs2=3) -> next cycle issue_valid=1, func=0, rd=1, addr=0x00.
REQ-030 Push 0x012300 then 0x041100 (rs1=1) back-to-back -> first issues, then two stall=1 bubbles, second issues on third cycle after first (macro defined); no bubbles with macro undefined.
REQ-031 Push 0xC12345, 0xF00000, then 0x212300 -> illegal_cnt=2, only func=2 issues, no bubble from dropped entries.
REQ-032 Hold issue blocked by hazard, push 4 instructions -> fifo_count=4, in_ready=0, 5th push not accepted; one pop with in_valid high -> no simultaneous push, count 3 then back to 4.
REQ-033 Buffer holding 3 entries with hazard pending, assert flush one cycle -> fifo_count=0, issue_valid=0, next push 0x056700 issues with no stall.
REQ-034 Drive 300 illegal instructions -> illegal_cnt saturates at 255.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: buffers 24-bit ALU instructions in a small FIFO and issues at most
// one per cycle to the downstream ALU pipeline. Illegal opcodes (func 12..15)
// are dropped at the head and counted in a saturating counter.
// Optional feature macro: ALU_ISSUE_HAZARD_CHECK_EN -- when defined, a two-slot
// scoreboard of recently issued destinations holds back a head instruction
// whose sources match, inserting stall bubbles until the hazard clears.
module alu_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [23:0]                   in_instr,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [3:0]                    func,
    output logic [3:0]                    rd,
    output logic [3:0]                    rs1,
    output logic [3:0]                    rs2,
    output logic [7:0]                    addr,
    output logic                          issue_valid,
    output logic                          stall,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              illegal_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    logic [23:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [23:0] head;
    logic        head_vld;
    logic        head_legal;
    logic        hazard;
    logic        push;
    logic        pop;
    logic        issue_now;

    assign head       = mem[rd_ptr];
    assign head_vld   = (fifo_count != '0);
    assign head_legal = (head[23:20] < 4'd12);

    assign in_ready  = (fifo_count < DEPTH_C) && !flush;
    assign push      = in_valid && in_ready;
    // Illegal heads always leave; legal heads leave only when hazard-free.
    assign pop       = head_vld && !flush && (!head_legal || !hazard);
    assign issue_now = head_vld && !flush && head_legal && !hazard;

`ifdef ALU_ISSUE_HAZARD_CHECK_EN
    logic       sb_vld_s0;
    logic       sb_vld_s1;
    logic [3:0] sb_rd_s0;
    logic [3:0] sb_rd_s1;

    // A source of the head matching any live recent destination is a hazard.
    always_comb begin
        hazard = 1'b0;
        if (head_vld && head_legal) begin
            if (sb_vld_s0 && ((head[15:12] == sb_rd_s0) || (head[11:8] == sb_rd_s0)))
                hazard = 1'b1;
            if (sb_vld_s1 && ((head[15:12] == sb_rd_s1) || (head[11:8] == sb_rd_s1)))
                hazard = 1'b1;
        end
    end

    // Shift the last two issue slots; bubbles, drops and idle cycles record invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld_s0 <= 1'b0;
            sb_vld_s1 <= 1'b0;
            sb_rd_s0  <= '0;
            sb_rd_s1  <= '0;
        end else if (flush) begin
            sb_vld_s0 <= 1'b0;
            sb_vld_s1 <= 1'b0;
        end else begin
            sb_vld_s1 <= sb_vld_s0;
            sb_rd_s1  <= sb_rd_s0;
            sb_vld_s0 <= issue_now;
            sb_rd_s0  <= head[19:16];
        end
    end
`else
    assign hazard = 1'b0;
`endif

    // Instruction storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + OCC_W'(1);
                2'b01:   fifo_count <= fifo_count - OCC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue register: real instruction, hazard bubble, drop or idle each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            stall       <= 1'b0;
            func        <= '0;
            rd          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            addr        <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
            stall       <= 1'b0;
        end else if (!head_vld) begin
            issue_valid <= 1'b0;
            stall       <= 1'b0;
        end else if (!head_legal) begin
            issue_valid <= 1'b0;
            stall       <= 1'b0;
            if (illegal_cnt != {CNT_W{1'b1}})
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end else if (hazard) begin
            issue_valid <= 1'b0;
            stall       <= 1'b1;
            func        <= '0;
        end else begin
            issue_valid <= 1'b1;
            stall       <= 1'b0;
            func        <= head[23:20];
            rd          <= head[19:16];
            rs1         <= head[15:12];
            rs2         <= head[11:8];
            addr        <= head[7:0];
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: legal instructions are queued as expected issues
// when accepted and compared in order whenever the DUT raises issue_valid.
module tb_alu_issue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic [23:0]              in_instr;
    logic                     in_ready;
    logic                     flush;
    logic [3:0]               func, rd, rs1, rs2;
    logic [7:0]               addr;
    logic                     issue_valid;
    logic                     stall;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [CNT_W-1:0]         illegal_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [23:0] exp_q[$];

    alu_issue #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .func(func), .rd(rd), .rs1(rs1),
        .rs2(rs2), .addr(addr), .issue_valid(issue_valid), .stall(stall),
        .fifo_count(fifo_count), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [23:0] x);
        return x[23:20] < 4'd12;
    endfunction

    // Present one instruction until accepted (bounded).
    task automatic push_wait(input logic [23:0] x);
        in_valid = 1'b1;
        in_instr = x;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                if (is_legal(x))
                    exp_q.push_back(x);
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            tick();
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (3) tick();
    endtask

    // Compare every issued instruction against the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && issue_valid) begin
            if (exp_q.size() == 0)
                check("issue_unexpected", exp_q.size(), 32'd1);
            else
                check("issue_order", {8'h0, func, rd, rs1, rs2, addr}, {8'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_count", fifo_count, 0);
        check("rst_illegal", illegal_cnt, 0);
        check("rst_fields", {func, rd, rs1, rs2, addr}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single add issues one cycle after push.
        push_wait(24'h012300);
        check("add_count", fifo_count, 1);
        tick();
        check("add_valid", issue_valid, 1);
        check("add_func", func, 0);
        check("add_rd", rd, 1);
        check("add_addr", addr, 8'h00);
        check("add_stall", stall, 0);
        check("add_count_after", fifo_count, 0);
        repeat (3) tick();

        // Back-to-back RAW dependence.
        push_wait(24'h012300);
        push_wait(24'h041100);
        check("raw_first_valid", issue_valid, 1);
        check("raw_first_rd", rd, 1);
`ifdef ALU_ISSUE_HAZARD_CHECK_EN
        tick();
        check("raw_bubble1", {issue_valid, stall, func, rd}, {1'b0, 1'b1, 4'd0, 4'd1});
        tick();
        check("raw_bubble2", {issue_valid, stall, func, rd}, {1'b0, 1'b1, 4'd0, 4'd1});
        tick();
        check("raw_second", {issue_valid, stall, rd, rs1}, {1'b1, 1'b0, 4'd4, 4'd1});
`else
        tick();
        check("raw_second", {issue_valid, stall, rd, rs1}, {1'b1, 1'b0, 4'd4, 4'd1});
`endif
        repeat (3) tick();

        // Illegal opcodes dropped without bubbles.
        push_wait(24'hC12345);
        push_wait(24'hF00000);
        check("ill_drop1", {issue_valid, stall}, 2'b00);
        push_wait(24'h212300);
        check("ill_drop2", {issue_valid, stall}, 2'b00);
        check("ill_cnt_mid", illegal_cnt, 2);
        tick();
        check("ill_issue", {issue_valid, stall, func}, {1'b1, 1'b0, 4'd2});
        check("ill_cnt", illegal_cnt, 2);
        repeat (3) tick();

        // Flush discards a buffered entry and the push presented with it.
        push_wait(24'h033300);
        flush = 1'b1; in_valid = 1'b1; in_instr = 24'h0AAAAA;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush_count", fifo_count, 0);
        check("flush_outputs", {issue_valid, stall}, 2'b00);
        check("flush_illegal_kept", illegal_cnt, 2);
        tick();
        check("flush_no_issue", {issue_valid, fifo_count}, 0);
        push_wait(24'h056700);
        tick();
        check("post_flush_issue", {issue_valid, stall, rd}, {1'b1, 1'b0, 4'd5});
        repeat (3) tick();

`ifdef ALU_ISSUE_HAZARD_CHECK_EN
        // Dependent chain fills the buffer.
        for (int i = 0; i < 30 && fifo_count != 3'(DEPTH); i++)
            push_wait(24'h011100 | 24'(i));
        check("full_count", fifo_count, DEPTH);
        check("full_not_ready", in_ready, 0);
        in_valid = 1'b1; in_instr = 24'h0111FF;
        for (int i = 0; i < 20 && fifo_count == 3'(DEPTH); i++)
            tick();
        check("full_pop_no_push", fifo_count, DEPTH - 1);
        check("full_ready_again", in_ready, 1);
        exp_q.push_back(24'h0111FF);
        tick();
        in_valid = 1'b0;
        check("full_refill", fifo_count, DEPTH);
        drain();

        // Flush with three entries behind a pending hazard.
        for (int i = 0; i < 30 && fifo_count != 3'd3; i++)
            push_wait(24'h011180 | 24'(i));
        check("hz_count3", fifo_count, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("hz_flush", {fifo_count, issue_valid, stall}, 0);
        push_wait(24'h056700);
        tick();
        check("hz_post_flush", {issue_valid, stall, rd}, {1'b1, 1'b0, 4'd5});
        repeat (3) tick();
`endif

        // Reset mid-operation discards buffered work.
        push_wait(24'h0C1200);
        in_valid = 1'b1; in_instr = 24'h0D1300;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_state", {fifo_count, issue_valid, stall}, 0);
        check("mid_rst_cnt", illegal_cnt, 0);
        check("mid_rst_fields", {func, rd, rs1, rs2, addr}, 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        push_wait(24'h0789AB);
        check("after_rst_count", fifo_count, 1);
        tick();
        check("after_rst_issue", {issue_valid, rd, addr}, {1'b1, 4'd7, 8'hAB});
        repeat (3) tick();

        // Illegal counter saturation.
        for (int i = 0; i < 100; i++)
            push_wait(24'hE00000 | 24'(i));
        repeat (2) tick();
        check("sat_mid", illegal_cnt, 100);
        for (int i = 0; i < 200; i++)
            push_wait(24'hC00000 | 24'(i));
        repeat (2) tick();
        check("sat_final", illegal_cnt, 255);
        check("sat_no_issue", issue_valid, 0);

        drain();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
